mag_cmp_arbiter: RTL
====================

// Module: mag_cmp_arbiter
// PURPOSE
//   Shares one 8-bit unsigned magnitude_comparator between NUM_REQ requesters.
//   - Round-robin arbitration; registered operand capture; registered LT/EQ/GT result.
//   - Per-requester req/gnt/done handshake.
//   - Sits between client blocks and the comparator datapath; owns all comparator sequencing.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8
//   DATA_W   8   operand width; must be 8 (fixed width of the shared comparator)
// PORTS
//   clk         in   1                clock; all state on rising edge
//   rst_n       in   1                reset; asynchronous, active-low
//   req         in   NUM_REQ          req[i]=1: requester i has operands valid on a_in/b_in slice i
//   a_in        in   NUM_REQ*DATA_W   operand A, slice i = [i*8 +: 8]
//   b_in        in   NUM_REQ*DATA_W   operand B, slice i = [i*8 +: 8]
//   gnt         out  NUM_REQ          one-hot, 1-cycle pulse: operands of i captured
//   done        out  NUM_REQ          one-hot, 1-cycle pulse: result for i valid on lt/eq/gt
//   lt,eq,gt    out  1 each           A<B, A==B, A>B (unsigned); exactly one high after 1st result
//   busy        out  1                state != IDLE
//   stat_count  out  16               completed-operation count (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, gnt=0, done=0, lt=eq=gt=0, busy=0,
//     stat_count=0, rr_ptr=NUM_REQ-1 (req[0] wins first).
//   Reset mid-operation: in-flight op dropped; no done issued.
//   FSM, registered state:
//     IDLE: if |req, arbitrate -> CMP; else stay IDLE.
//     CMP : comparator evaluates captured op_a/op_b -> DONE.
//     DONE: if |req, arbitrate -> CMP (back-to-back); else -> IDLE.
//   Arbitrate, on the edge leaving IDLE/DONE:
//     - winner = first asserted req scanning rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
//     - op_a/op_b <= winner's slices; owner <= winner; rr_ptr <= winner.
//     - gnt[winner]=1 during the following (CMP) cycle.
//   Edge leaving CMP: lt/eq/gt <= comparator outputs; done[owner]=1 during the DONE cycle.
//   lt/eq/gt hold their value until the next DONE; they are meaningful only with done.
//   Latency: req seen in IDLE at cycle N -> gnt in N+1 -> done in N+2.
//   Throughput: one op per 2 cycles under continuous requests.
//   Requester rules:
//     - hold req and operands stable until gnt;
//     - drop req the cycle after gnt unless another op is wanted;
//     - a req still high in DONE is treated as a new request.
//   Operand changes after gnt do not affect the in-flight result.
//   Only one requester is ever granted per arbitration; others wait (no drop, no timeout).
//   Fairness: with all req high, grant order is 0,1,..,NUM_REQ-1,0,...
//     Max wait = 2*NUM_REQ cycles.
// CONFIGURATION
//   MAG_ARB_STATS_EN defined:
//     - stat_count increments by 1 on every done pulse;
//     - saturates at 16'hFFFF; cleared only by reset.
//   Not defined: stat_count tied to 16'h0000 and no counter flops are built.
// STRUCTURE
//   Shared package mag_cmp_pkg:
//     - CMP_W=8;
//     - state enum {ST_IDLE, ST_CMP, ST_DONE};
//     - function rr_pick(req, ptr) returning the winner index.
//   Sub-module: magnitude_comparator (existing, unchanged), one instance on op_a/op_b.
//   Everything else inline: FSM, rr pointer, operand/result registers, stats counter.
// TESTING
//   1 Single req[0], A=8'h35, B=8'h35 from IDLE
//       -> gnt[0] at N+1, done[0] at N+2, eq=1, lt=gt=0; busy high for 2 cycles.
//   2 req[2]: A=8'h80, B=8'h7F -> gt=1. Then A=8'h01, B=8'hFE -> lt=1.
//       Checks MSB decides the result and full 8-bit compare.
//   3 All 4 req held high
//       -> grants 0,1,2,3,0; one gnt every 2 cycles; done one cycle after each gnt.
//   4 req[1] and req[3] together after last grant=1
//       -> gnt[3] first, then gnt[1]; neither starved.
//   5 rst_n low during CMP of req[0]
//       -> gnt/done/busy/lt/eq/gt=0 immediately; no done[0] after release;
//          next arbitration starts from req[0].
//   6 MAG_ARB_STATS_EN: 3 ops -> stat_count=3; preload near 16'hFFFF via 70000 ops
//       (or force) -> holds 16'hFFFF. Without macro: stat_count always 0.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the shared magnitude-comparator arbiter.
package mag_cmp_pkg;

  localparam int unsigned CMP_W   = 8;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_DONE
  } state_t;

  // Round-robin winner: first asserted req after ptr, wrapping modulo n.
  // Returns 0 when nothing is requested; callers qualify with |req.
  function automatic logic [PTR_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [PTR_W-1:0]   ptr,
    input int unsigned        n
  );
    logic [PTR_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = ({29'd0, ptr} + k) % n;
      if (!found && (k <= n) && req[idx]) begin
        win   = idx[PTR_W-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mag_cmp_arbiter_if.sv
// Requester-side bus of mag_cmp_arbiter: req/gnt/done handshake, operands, result.
interface mag_cmp_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] a_in;
  logic [NUM_REQ*DATA_W-1:0] b_in;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic                      lt;
  logic                      eq;
  logic                      gt;
  logic                      busy;
  logic [15:0]               stat_count;

  modport master (
    output req, a_in, b_in,
    input  gnt, done, lt, eq, gt, busy, stat_count
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, done, lt, eq, gt, busy, stat_count
  );

endinterface

// File: rtl/magnitude_comparator.sv
// 8-bit unsigned magnitude comparator (combinational).
module magnitude_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/mag_cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude_comparator among NUM_REQ requesters.
// Optional completed-op counter on stat_count when MAG_ARB_STATS_EN is defined.
module mag_cmp_arbiter
  import mag_cmp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  mag_cmp_arbiter_if.slave bus
);

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   winner;
  logic [MAX_REQ-1:0] req_ext;
  logic               any_req;
  logic               arb;
  logic [CMP_W-1:0]   op_a;
  logic [CMP_W-1:0]   op_b;
  logic [DATA_W-1:0]  a_sel;
  logic [DATA_W-1:0]  b_sel;
  logic               cmp_lt;
  logic               cmp_eq;
  logic               cmp_gt;
  logic               lt_q;
  logic               eq_q;
  logic               gt_q;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = bus.req;
  end

  assign any_req = |bus.req;
  assign arb     = any_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign winner  = rr_pick(req_ext, rr_ptr, NUM_REQ);

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        a_sel = bus.a_in[i*DATA_W +: DATA_W];
        b_sel = bus.b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req) state_d = ST_CMP;
      ST_CMP:  state_d = ST_DONE;
      ST_DONE: state_d = any_req ? ST_CMP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // gnt/done decode from state and owner so they drop with reset immediately.
  always_comb begin
    bus.gnt  = '0;
    bus.done = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.gnt[i]  = (state_q == ST_CMP)  && (owner == PTR_W'(i));
      bus.done[i] = (state_q == ST_DONE) && (owner == PTR_W'(i));
    end
    bus.busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PTR_W'(NUM_REQ - 1);
      owner  <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else if (arb) begin
      rr_ptr <= winner;
      owner  <= winner;
      op_a   <= a_sel;
      op_b   <= b_sel;
    end
  end

  magnitude_comparator u_cmp (
    .a  (op_a),
    .b  (op_b),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
    end else if (state_q == ST_CMP) begin
      lt_q <= cmp_lt;
      eq_q <= cmp_eq;
      gt_q <= cmp_gt;
    end
  end

  assign bus.lt = lt_q;
  assign bus.eq = eq_q;
  assign bus.gt = gt_q;

`ifdef MAG_ARB_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else if ((state_q == ST_DONE) && (stat_q != '1)) stat_q <= stat_q + 16'd1;
  end

  assign bus.stat_count = stat_q;
`else
  assign bus.stat_count = '0;
`endif

endmodule
